block_backing_memory: RTL and testbench
=======================================

Name: block_backing_memory

Overview:
- Multi-cycle, block-granular main memory that sits directly downstream of the direct-mapped write-back cache.
- Serves one 128-bit block read or write at a time, with a fixed access latency.
- Uses a ready/valid handshake: the cache issues write-back and allocate requests and waits for completion.
- Keeps per-block read/write access counters for miss-penalty analysis.

Parameters:
- BLOCK_SIZE, 16, block size in bytes; data width = BLOCK_SIZE*8.
- NUM_BLOCKS, 1024, number of blocks stored; address index width AW = CLOG2(NUM_BLOCKS).
- DELAY, 50, access latency in cycles (legal range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- is_input_valid  in  1  request valid
- addr  in  32  block address (byte address already shifted right by CLOG2(BLOCK_SIZE))
- mem_read  in  1  read request
- mem_write  in  1  write request
- din  in  BLOCK_SIZE*8  write data block
- mem_ready  out  1  block idle, able to accept a request this cycle
- is_output_valid  out  1  read data valid (one-cycle pulse)
- dout  out  BLOCK_SIZE*8  read data block
- num_reads  out  32  count of accepted reads
- num_writes  out  32  count of accepted writes

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk; all state updates on posedge clk.
- Reset values:
  - state=IDLE, mem_ready=1, is_output_valid=0, dout=0, num_reads=0, num_writes=0, latency counter=0.
  - Every array entry cleared to 0.
- Reset asserted mid-operation: abandons the in-flight request. A pending write is NOT committed; no is_output_valid pulse is produced.
- Index: addr[AW-1:0]; upper address bits ignored, so out-of-range addresses wrap modulo NUM_BLOCKS.
- Acceptance (cycle T): is_input_valid & mem_ready & (mem_read ^ mem_write).
  - On acceptance, latch index, op and din; increment num_reads or num_writes.
  - Requests with both or neither of mem_read/mem_write are ignored: no state change, no count.
  - Requests while mem_ready=0 are ignored, not queued. The requester may hold is_input_valid high while waiting.
- States:
  - IDLE: mem_ready=1. On acceptance, load counter=DELAY-1 and go to BUSY.
  - BUSY: mem_ready=0. Decrement the counter each cycle; go to DONE when it reaches 0 (cycles T+1..T+DELAY-1).
  - DONE (cycle T+DELAY): mem_ready=0.
    - Read: is_output_valid=1 and dout=array[latched index] for exactly this cycle.
    - Write: array[latched index]<=latched din at the end of this cycle; is_output_valid stays 0.
    - Next state is IDLE.
  - Cycle T+DELAY+1: IDLE, mem_ready=1. A new request is acceptable in this cycle.
- dout is 0 whenever is_output_valid=0.
- Data coherence:
  - din changes after cycle T do not affect a write.
  - A read accepted immediately after a write to the same index returns the new data.
- Counters: 32-bit, wrap at 2^32-1 → 0.
- Total occupancy per request: DELAY+1 cycles from acceptance to next ready.

Test Plan:
- Reset, then read index 5 with DELAY=50 → mem_ready low from T+1; is_output_valid=1 only at T+50 with dout=0; mem_ready=1 at T+51; num_reads=1.
- Write din=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to index 7, then a back-to-back read of index 7 in the first ready cycle → read returns the same 128-bit value; num_writes=1, num_reads=1.
- Hold is_input_valid=1, mem_read=1 continuously (cache allocate pattern) → exactly one request accepted per DELAY+1 cycles; no extra is_output_valid pulses.
- Requests with mem_read=mem_write=1, and with both 0 → mem_ready stays 1, counters unchanged, no output pulse.
- Write to addr=NUM_BLOCKS+3, then read addr=3 → returns the written data (wrap-around).
- Accept a write to index 9, assert reset at T+20 → after reset mem_ready=1, a read of index 9 returns 0, counters are 0.

Source files
------------

// File: rtl/block_backing_memory_if.sv
// -----------------------------------------------------------------------------
// block_backing_memory_if
//   Request/response bundle between the write-back cache (master) and the
//   block backing memory (slave).
//
//   Master -> slave : is_input_valid, addr, mem_read, mem_write, din
//   Slave -> master : mem_ready, is_output_valid, dout, num_reads, num_writes
// -----------------------------------------------------------------------------
interface block_backing_memory_if #(
    parameter int BLOCK_SIZE = 16
);
    logic                    is_input_valid;
    logic [31:0]             addr;
    logic                    mem_read;
    logic                    mem_write;
    logic [BLOCK_SIZE*8-1:0] din;
    logic                    mem_ready;
    logic                    is_output_valid;
    logic [BLOCK_SIZE*8-1:0] dout;
    logic [31:0]             num_reads;
    logic [31:0]             num_writes;

    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        input  mem_ready, is_output_valid, dout, num_reads, num_writes
    );

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        output mem_ready, is_output_valid, dout, num_reads, num_writes
    );
endinterface

// File: rtl/block_backing_memory.sv
// -----------------------------------------------------------------------------
// block_backing_memory
//   Block-granular main memory behind the direct-mapped write-back cache.
//   Serves one block read or write at a time with a fixed latency of DELAY
//   cycles from acceptance to completion, then one more cycle before it is
//   ready again (DELAY+1 cycles total occupancy).
//
//   Ports:
//     clk    - clock, all state changes on its rising edge
//     reset  - synchronous, active-high; clears state, counters and contents
//     bus    - slave side of block_backing_memory_if (request/response,
//              access counters)
// -----------------------------------------------------------------------------
module block_backing_memory #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_BLOCKS = 1024,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    block_backing_memory_if.slave   bus
);
    localparam int DW = BLOCK_SIZE * 8;
    localparam int AW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_next;

    logic [AW-1:0]   r_idx;
    logic            r_op_read;
    logic [DW-1:0]   r_din;
    logic [DW-1:0]   r_mem [NUM_BLOCKS];

    logic            r_mem_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_dout;
    logic [31:0]     r_num_reads;
    logic [31:0]     r_num_writes;

    logic            w_accept;
    logic            w_unused_addr;

    // Address bits above the index are intentionally dropped (wrap modulo NUM_BLOCKS).
    assign w_unused_addr = ^bus.addr[31:AW];

    // A request is taken only when idle and exactly one of read/write is set.
    assign w_accept = bus.is_input_valid & (r_state == S_IDLE)
                    & (bus.mem_read ^ bus.mem_write);

    // Next-state and latency counter logic.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_BUSY;
                    w_cnt_next   = 8'(DELAY - 1);
                end else begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = r_cnt;
                end
            end
            S_BUSY: begin
                w_cnt_next = r_cnt - 8'd1;
                // Counter reaching 0 on this decrement means the next cycle is T+DELAY.
                if (r_cnt == 8'd1) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_cnt_next   = 8'd0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Latch the request on acceptance so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_op_read <= 1'b0;
            r_din     <= '0;
        end else if (w_accept) begin
            r_idx     <= bus.addr[AW-1:0];
            r_op_read <= bus.mem_read;
            r_din     <= bus.din;
        end
    end

    // Storage array; a write commits at the end of the DONE cycle, so a reset
    // that arrives earlier simply discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == S_DONE) && !r_op_read) begin
            r_mem[r_idx] <= r_din;
        end
    end

    // Registered handshake/response outputs, computed from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_mem_ready <= (w_next_state == S_IDLE);
            r_out_valid <= (w_next_state == S_DONE) & r_op_read;
            if ((w_next_state == S_DONE) && r_op_read) begin
                r_dout <= r_mem[r_idx];
            end else begin
                r_dout <= '0;
            end
        end
    end

    // Access counters, bumped at acceptance; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_reads  <= 32'd0;
            r_num_writes <= 32'd0;
        end else if (w_accept) begin
            if (bus.mem_read) begin
                r_num_reads  <= r_num_reads + 32'd1;
            end else begin
                r_num_writes <= r_num_writes + 32'd1;
            end
        end
    end

    assign bus.mem_ready       = r_mem_ready;
    assign bus.is_output_valid = r_out_valid;
    assign bus.dout            = r_dout;
    assign bus.num_reads       = r_num_reads;
    assign bus.num_writes      = r_num_writes;

endmodule

// File: tb/tb_block_backing_memory.sv
// -----------------------------------------------------------------------------
// tb_block_backing_memory
//   Self-checking bench: a fixed table of read/write vectors with hand-written
//   expected data, a few multi-cycle corner sequences (held request, illegal
//   op encodings, reset during a write) and a randomized phase checked against
//   a plain array-plus-counters reference model.
// -----------------------------------------------------------------------------
module tb_block_backing_memory;
    localparam int BLOCK_SIZE = 16;
    localparam int NUM_BLOCKS = 1024;
    localparam int DELAY      = 50;
    localparam int AW         = 10;

    logic clk;
    logic reset;

    block_backing_memory_if #(.BLOCK_SIZE(BLOCK_SIZE)) bus ();

    block_backing_memory #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_BLOCKS (NUM_BLOCKS),
        .DELAY      (DELAY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: contents plus access counters.
    logic [127:0] model_mem [NUM_BLOCKS];
    int unsigned  model_reads;
    int unsigned  model_writes;

    typedef struct {
        logic         rd;
        logic [31:0]  addr;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_BLOCKS; i++) model_mem[i] = '0;
        model_reads  = 0;
        model_writes = 0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one request from a ready negedge and follow it through DELAY+1 cycles.
    task automatic run_req(input logic rd, input logic [31:0] a, input logic [127:0] d,
                           output logic [127:0] rdata);
        int pulses;
        int pulse_k;
        int bad_busy;
        int bad_dout;
        pulses = 0; pulse_k = 0; bad_busy = 0; bad_dout = 0; rdata = '0;
        check("ready_before_req", 128'(bus.mem_ready), 128'(1));
        bus.addr           = a;
        bus.din            = d;
        bus.mem_read       = rd;
        bus.mem_write      = ~rd;
        bus.is_input_valid = 1'b1;
        @(negedge clk);
        bus.is_input_valid = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.din            = rnd128();
        bus.addr           = $urandom;
        if (rd) model_reads++; else model_writes++;
        for (int k = 1; k <= DELAY + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.is_output_valid) begin
                pulses++;
                pulse_k = k;
                rdata   = bus.dout;
            end else if (bus.dout !== '0) begin
                bad_dout++;
            end
            if (k <= DELAY && bus.mem_ready !== 1'b0) bad_busy++;
        end
        check("ready_after_req", 128'(bus.mem_ready), 128'(1));
        check("busy_window",     128'(bad_busy), 128'(0));
        check("dout_zero_idle",  128'(bad_dout), 128'(0));
        check("pulse_count",     128'(pulses), rd ? 128'(1) : 128'(0));
        if (rd) check("pulse_cycle", 128'(pulse_k), 128'(DELAY));
        check("num_reads",  128'(bus.num_reads),  128'(model_reads));
        check("num_writes", 128'(bus.num_writes), 128'(model_writes));
        if (!rd) model_mem[a[AW-1:0]] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] rdata;
        int pulses;
        int ready_hi;
        int bad;
        logic [31:0] a;

        bus.is_input_valid = 1'b0;
        bus.addr           = 32'd0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.din            = '0;
        reset              = 1'b1;
        model_clear();

        tbl[0] = '{1'b1, 32'd5,          128'd0, 128'd0};
        tbl[1] = '{1'b0, 32'd7,          128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'd0};
        tbl[2] = '{1'b1, 32'd7,          128'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        tbl[3] = '{1'b0, 32'd1027,       128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 128'd0};
        tbl[4] = '{1'b1, 32'd3,          128'd0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
        tbl[5] = '{1'b0, 32'hFFFF_FC01,  128'hA5A5_5A5A_FFFF_0000_1234_5678_9ABC_DEF0, 128'd0};
        tbl[6] = '{1'b1, 32'd1,          128'd0, 128'hA5A5_5A5A_FFFF_0000_1234_5678_9ABC_DEF0};
        tbl[7] = '{1'b1, 32'd1023,       128'd0, 128'd0};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values.
        check("rst_ready",      128'(bus.mem_ready),       128'(1));
        check("rst_valid",      128'(bus.is_output_valid), 128'(0));
        check("rst_dout",       bus.dout,                  128'd0);
        check("rst_num_reads",  128'(bus.num_reads),       128'(0));
        check("rst_num_writes", 128'(bus.num_writes),      128'(0));

        // Table of fixed vectors; each starts in the first ready cycle of the previous.
        for (int i = 0; i < 8; i++) begin
            run_req(tbl[i].rd, tbl[i].addr, tbl[i].din, rdata);
            if (tbl[i].rd) check("table_read_data", rdata, tbl[i].exp);
        end

        // Held read request: one acceptance per DELAY+1 cycles.
        bus.addr = 32'd7; bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.is_input_valid = 1'b1;
        pulses = 0; ready_hi = 0; bad = 0;
        for (int k = 1; k <= 3 * (DELAY + 1); k++) begin
            @(negedge clk);
            if (bus.is_output_valid) begin
                pulses++;
                if (bus.dout !== model_mem[7]) bad++;
            end
            if (bus.mem_ready) ready_hi++;
        end
        bus.is_input_valid = 1'b0; bus.mem_read = 1'b0;
        model_reads += 3;
        check("hold_pulses",    128'(pulses),        128'(3));
        check("hold_ready_hi",  128'(ready_hi),      128'(3));
        check("hold_data",      128'(bad),           128'(0));
        check("hold_num_reads", 128'(bus.num_reads), 128'(model_reads));

        // Illegal encodings (both set, neither set) are ignored.
        for (int e = 0; e < 2; e++) begin
            bus.addr = 32'd7;
            bus.mem_read = (e == 0); bus.mem_write = (e == 0); bus.is_input_valid = 1'b1;
            bad = 0; pulses = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (bus.mem_ready !== 1'b1) bad++;
                if (bus.is_output_valid) pulses++;
            end
            bus.is_input_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
            check("illegal_ready",      128'(bad),            128'(0));
            check("illegal_pulses",     128'(pulses),         128'(0));
            check("illegal_num_reads",  128'(bus.num_reads),  128'(model_reads));
            check("illegal_num_writes", 128'(bus.num_writes), 128'(model_writes));
        end

        // Randomized phase against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic rd;
            rd = ($urandom_range(0, 1) == 1);
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            run_req(rd, a, rnd128(), rdata);
            if (rd) check("rand_read_data", rdata, model_mem[a[AW-1:0]]);
        end

        // Reset in the middle of a write to index 9 (reset during cycle T+20).
        check("ready_before_rst_write", 128'(bus.mem_ready), 128'(1));
        bus.addr = 32'd9; bus.din = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
        bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.is_input_valid = 1'b1;
        @(negedge clk);
        bus.is_input_valid = 1'b0; bus.mem_write = 1'b0;
        pulses = 0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (bus.is_output_valid) pulses++;
        end
        do_reset();
        model_clear();
        check("midrst_pulses",     128'(pulses),              128'(0));
        check("midrst_ready",      128'(bus.mem_ready),       128'(1));
        check("midrst_valid",      128'(bus.is_output_valid), 128'(0));
        check("midrst_num_reads",  128'(bus.num_reads),       128'(0));
        check("midrst_num_writes", 128'(bus.num_writes),      128'(0));
        run_req(1'b1, 32'd9, 128'd0, rdata);
        check("midrst_read9", rdata, 128'd0);
        run_req(1'b1, 32'd7, 128'd0, rdata);
        check("midrst_read7_cleared", rdata, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
